// File: rtl/fpga_uart_pkg.sv
// Shared types and constants for the FPGA UART receiver.
package fpga_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam int         OS   = 16;
    localparam logic [3:0] S0   = 4'd7;
    localparam logic [3:0] S1   = 4'd8;
    localparam logic [3:0] S2   = 4'd9;
    localparam logic [3:0] LAST = 4'(OS - 1);

    // Clocks per oversample tick, never below one.
    function automatic int div_calc(input int clk_hz, input int baud);
        int d;
        d = clk_hz / (baud * OS);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/fpga_uart_rx_fifo.sv
// Small registered byte FIFO with extra-MSB pointers for full/empty detection.
module fpga_uart_rx_fifo
    import fpga_uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              empty,
    output logic              full
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_pop;
    logic              do_push;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop    = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push   = push && (!full || do_pop);
    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fpga_uart_rx.sv
// 16x oversampling UART receiver with majority voting, framing check and
// a byte FIFO presented on a valid/ready interface.
module fpga_uart_rx
    import fpga_uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLK100MHZ,
    input  logic       ck_rst,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int            DIV       = div_calc(CLK_HZ, BAUD);
    localparam int            CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(DIV - 1);

    rx_state_t     state_q, state_d;
    logic          rx_meta, rxs;
    logic [CW-1:0] tick_cnt;
    logic          tick;
    logic [3:0]    t_q;
    logic [2:0]    bit_idx;
    logic          smp0, smp1;
    logic          maj;
    logic [7:0]    shreg;
    logic          push_req;
    logic          ferr_req;
    logic          fifo_empty;
    logic          fifo_full;

    assign tick     = (state_q != IDLE) && (tick_cnt == TICK_LAST);
    assign maj      = (smp0 & smp1) | (smp0 & rxs) | (smp1 & rxs);
    assign busy     = (state_q != IDLE);
    assign rx_valid = !fifo_empty;

    always_comb begin
        state_d  = state_q;
        push_req = 1'b0;
        ferr_req = 1'b0;
        case (state_q)
            IDLE: if (!rxs) state_d = START;
            START: begin
                if (tick && t_q == S2 && maj) state_d = IDLE;
                else if (tick && t_q == LAST) state_d = DATA;
            end
            DATA: if (tick && t_q == LAST && bit_idx == 3'd7) state_d = STOP;
            // Rearm at mid-stop so the next start edge is never missed.
            STOP: begin
                if (tick && t_q == S2) begin
                    if (maj) begin
                        push_req = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        ferr_req = 1'b1;
                        state_d  = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: if (rxs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (ck_rst) begin
            state_q   <= IDLE;
            rx_meta   <= 1'b1;
            rxs       <= 1'b1;
            tick_cnt  <= '0;
            t_q       <= '0;
            bit_idx   <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta   <= uart_rxd;
            rxs       <= rx_meta;
            frame_err <= ferr_req;
            overrun   <= push_req && fifo_full && !rx_ready;
            if (state_q == IDLE || tick) tick_cnt <= '0;
            else                         tick_cnt <= tick_cnt + 1'b1;
            if (state_q == IDLE) t_q <= '0;
            else if (tick)       t_q <= t_q + 4'd1;
            if (state_q == START) bit_idx <= '0;
            else if (state_q == DATA && tick && t_q == LAST) bit_idx <= bit_idx + 3'd1;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (tick && t_q == S0) smp0 <= rxs;
        if (tick && t_q == S1) smp1 <= rxs;
        if (state_q == DATA && tick && t_q == S2) shreg <= {maj, shreg[7:1]};
    end

    fpga_uart_rx_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK100MHZ),
        .rst       (ck_rst),
        .push      (push_req),
        .push_data (shreg),
        .pop       (rx_ready),
        .head_data (rx_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_fpga_uart_rx.sv
// Directed bench for fpga_uart_rx at DIV=4 (64 clocks per bit).
module tb_fpga_uart_rx;
    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       ck_rst = 1'b0;
    logic       uart_rxd = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int        ferr_total = 0;
    int        ovr_total = 0;
    int        valid_total = 0;
    logic [7:0] pop_q[$];

    fpga_uart_rx #(
        .CLK_HZ     (50000000),
        .BAUD       (781250),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK100MHZ (clk),
        .ck_rst    (ck_rst),
        .uart_rxd  (uart_rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #10 clk = ~clk;

    // Observe on the falling edge; a pop happens on the following rising edge.
    always @(negedge clk) begin
        if (!ck_rst) begin
            if (frame_err) ferr_total++;
            if (overrun) ovr_total++;
            if (rx_valid) valid_total++;
            if (rx_valid && rx_ready) pop_q.push_back(rx_data);
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int clocks);
        uart_rxd = v;
        wait_clk(clocks);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(d[i], BIT);
        drive(stop_v, BIT);
        uart_rxd = 1'b1;
    endtask

    task automatic expect_pop(input string name, input int idx, input logic [7:0] exp);
        checks++;
        if (pop_q.size() <= idx) begin
            errors++;
            $display("FAIL %s: no byte popped, required 0x%02h", name, exp);
        end else if (pop_q[idx] !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h, required 0x%02h", name, pop_q[idx], exp);
        end
    endtask

    task automatic test_reset();
        ck_rst = 1'b1;
        wait_clk(3);
        ck_rst = 1'b0;
        checks++;
        if ({rx_valid, rx_data, frame_err, overrun, busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%02h fe=%b ov=%b busy=%b, required all 0",
                     rx_valid, rx_data, frame_err, overrun, busy);
        end
    endtask

    task automatic test_single_byte();
        int pb, vb, fb, ob;
        pb = pop_q.size(); vb = valid_total; fb = ferr_total; ob = ovr_total;
        rx_ready = 1'b1;
        send_frame(8'h55, 1'b1);
        wait_clk(20);
        expect_pop("single_data", pb, 8'h55);
        checks++;
        if (valid_total - vb !== 1) begin
            errors++;
            $display("FAIL single_valid_cycles: got %0d, required 1", valid_total - vb);
        end
        checks++;
        if ((ferr_total - fb) !== 0 || (ovr_total - ob) !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_flags: got fe=%0d ov=%0d busy=%b, required 0 0 0",
                     ferr_total - fb, ovr_total - ob, busy);
        end
    endtask

    task automatic test_back_to_back();
        int pb;
        pb = pop_q.size();
        rx_ready = 1'b0;
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        wait_clk(20);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'hA3) begin
            errors++;
            $display("FAIL b2b_held: got v=%b d=0x%02h, required v=1 d=0xa3", rx_valid, rx_data);
        end
        rx_ready = 1'b1;
        wait_clk(5);
        rx_ready = 1'b0;
        expect_pop("b2b_first", pb, 8'hA3);
        expect_pop("b2b_second", pb + 1, 8'h0F);
        checks++;
        if (rx_valid !== 1'b0 || pop_q.size() !== pb + 2) begin
            errors++;
            $display("FAIL b2b_drained: got v=%b pops=%0d, required v=0 pops=2",
                     rx_valid, pop_q.size() - pb);
        end
    endtask

    task automatic test_glitch();
        int pb, fb;
        pb = pop_q.size(); fb = ferr_total;
        rx_ready = 1'b1;
        drive(1'b0, 8);
        uart_rxd = 1'b1;
        wait_clk(4);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL glitch_detect: busy got %b, required 1", busy);
        end
        wait_clk(BIT - 12);
        checks++;
        if (busy !== 1'b0 || pop_q.size() !== pb || ferr_total !== fb) begin
            errors++;
            $display("FAIL glitch_reject: got busy=%b pops=%0d fe=%0d, required 0 0 0",
                     busy, pop_q.size() - pb, ferr_total - fb);
        end
        send_frame(8'h3C, 1'b1);
        wait_clk(20);
        expect_pop("glitch_followup", pb, 8'h3C);
    endtask

    task automatic test_frame_error();
        int pb, fb;
        pb = pop_q.size(); fb = ferr_total;
        rx_ready = 1'b1;
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) drive(i == 0 || i == 6, BIT);
        drive(1'b0, 2 * BIT);
        checks++;
        if (busy !== 1'b1 || ferr_total - fb !== 1) begin
            errors++;
            $display("FAIL ferr_pulse: got busy=%b fe=%0d, required busy=1 fe=1",
                     busy, ferr_total - fb);
        end
        uart_rxd = 1'b1;
        wait_clk(10);
        checks++;
        if (busy !== 1'b0 || rx_valid !== 1'b0 || pop_q.size() !== pb) begin
            errors++;
            $display("FAIL ferr_discard: got busy=%b v=%b pops=%0d, required 0 0 0",
                     busy, rx_valid, pop_q.size() - pb);
        end
        send_frame(8'h42, 1'b1);
        wait_clk(20);
        expect_pop("ferr_followup", pb, 8'h42);
        checks++;
        if (ferr_total - fb !== 1) begin
            errors++;
            $display("FAIL ferr_count: got %0d, required 1", ferr_total - fb);
        end
    endtask

    task automatic test_overrun();
        int pb, ob;
        pb = pop_q.size(); ob = ovr_total;
        rx_ready = 1'b0;
        for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1);
        wait_clk(10);
        checks++;
        if (ovr_total - ob !== 0) begin
            errors++;
            $display("FAIL overrun_early: got %0d pulses, required 0", ovr_total - ob);
        end
        send_frame(8'h05, 1'b1);
        wait_clk(10);
        checks++;
        if (ovr_total - ob !== 1) begin
            errors++;
            $display("FAIL overrun_pulse: got %0d pulses, required 1", ovr_total - ob);
        end
        rx_ready = 1'b1;
        wait_clk(10);
        rx_ready = 1'b0;
        for (int b = 0; b < 4; b++) expect_pop("overrun_drain", pb + b, 8'(b + 1));
        checks++;
        if (pop_q.size() - pb !== 4) begin
            errors++;
            $display("FAIL overrun_drain_count: got %0d, required 4", pop_q.size() - pb);
        end
    endtask

    task automatic test_mid_frame_reset();
        int pb, fb, ob;
        pb = pop_q.size(); fb = ferr_total; ob = ovr_total;
        rx_ready = 1'b1;
        drive(1'b0, BIT);
        drive(1'b1, 3 * BIT + 20);
        ck_rst = 1'b1;
        wait_clk(1);
        ck_rst = 1'b0;
        checks++;
        if ({rx_valid, rx_data, frame_err, overrun, busy} !== 12'h000) begin
            errors++;
            $display("FAIL midreset_outputs: got v=%b d=%02h fe=%b ov=%b busy=%b, required all 0",
                     rx_valid, rx_data, frame_err, overrun, busy);
        end
        drive(1'b1, BIT - 21 + 5 * BIT);
        send_frame(8'h7E, 1'b1);
        wait_clk(20);
        expect_pop("midreset_followup", pb, 8'h7E);
        checks++;
        if (pop_q.size() - pb !== 1 || ferr_total !== fb || ovr_total !== ob) begin
            errors++;
            $display("FAIL midreset_flags: got pops=%0d fe=%0d ov=%0d, required 1 0 0",
                     pop_q.size() - pb, ferr_total - fb, ovr_total - ob);
        end
    endtask

    initial begin
        wait_clk(2);
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_mid_frame_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
